// File: rtl/drum_trigger_queue.sv
// drum_trigger_queue
// Buffers classified drum hits in a small FIFO and hands them to the SPI slave
// one at a time. The next command goes out only after the previous one has been
// acknowledged or has timed out. A per-drum holdoff counter suppresses sensor
// bounce. Sticky status flags report dropped hits and discarded commands.

module drum_trigger_queue #(
   parameter int DEPTH          = 8,
   parameter int NUM_DRUMS      = 8,
   parameter int HOLDOFF_CYCLES = 500000,
   parameter int ACK_TIMEOUT    = 2000000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     hit_valid,
   input  logic [3:0]               hit_code,
   output logic                     drum_trigger_valid,
   output logic [3:0]               drum_code,
   input  logic                     command_sent,
   input  logic                     status_clr,
   output logic [$clog2(DEPTH):0]   queue_count,
   output logic                     overflow,
   output logic                     ack_timeout
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF_CYCLES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

   typedef enum logic {
      IDLE     = 1'b0,
      WAIT_ACK = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_nextState;

   logic [3:0]        r_mem [DEPTH];
   logic [PW-1:0]     r_wrPtr;
   logic [PW-1:0]     r_rdPtr;
   logic [CW-1:0]     r_count;
   logic [HW-1:0]     r_holdoff [16];
   logic [TW-1:0]     r_timer;
   logic              r_valid;
   logic [3:0]        r_code;
   logic              r_overflow;
   logic              r_ackTimeout;

   logic              w_empty;
   logic              w_full;
   logic              w_codeOk;
   logic              w_holdBusy;
   logic              w_candidate;
   logic              w_pop;
   logic              w_push;
   logic              w_overflowSet;
   logic              w_ackTimeoutSet;
   logic              w_timerExpired;

   assign w_empty        = (r_count == '0);
   assign w_full         = (r_count == FULL_COUNT);
   assign w_codeOk       = (int'(hit_code) < NUM_DRUMS);
   assign w_holdBusy     = (r_holdoff[hit_code] != '0);
   assign w_timerExpired = (r_timer == TIMER_LAST);

   // A hit that survives the code and holdoff filters either enters the FIFO or, when full with no room freed this edge, is lost.
   assign w_candidate    = hit_valid && w_codeOk && !w_holdBusy;
   assign w_push         = w_candidate && (!w_full || w_pop);
   assign w_overflowSet  = w_candidate && w_full && !w_pop;

   // Dispatch state register; reset abandons any outstanding command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Issue when idle with queued work; leave WAIT_ACK on ack or timer expiry.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_nextState = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            if (command_sent || w_timerExpired) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   // Decode the per-state actions: pop-and-issue from IDLE, timeout report from WAIT_ACK (an ack on the expiry edge wins).
   always_comb begin
      w_pop           = 1'b0;
      w_ackTimeoutSet = 1'b0;
      case (r_state)
         IDLE:     w_pop           = !w_empty;
         WAIT_ACK: w_ackTimeoutSet = w_timerExpired && !command_sent;
         default:  w_pop           = 1'b0;
      endcase
   end

   // Acknowledge timer restarts from zero on every issue and counts while waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (w_pop) begin
         r_timer <= '0;
      end else if (r_state == WAIT_ACK) begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // FIFO storage needs no reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= hit_code;
      end
   end

   // FIFO pointers wrap naturally at DEPTH; the count tracks occupancy after each edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Holdoff counters arm only on an accepted hit and otherwise bleed down to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            r_holdoff[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (w_push && (hit_code == 4'(i))) begin
               r_holdoff[i] <= HOLD_LOAD;
            end else if (r_holdoff[i] != '0) begin
               r_holdoff[i] <= r_holdoff[i] - 1'b1;
            end
         end
      end
   end

   // Issue pulse lasts one cycle; the code stays put until the next issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_code  <= '0;
      end else begin
         r_valid <= w_pop;
         if (w_pop) begin
            r_code <= r_mem[r_rdPtr];
         end
      end
   end

   // Sticky flags: clear first so that a set on the same edge overrides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow   <= 1'b0;
         r_ackTimeout <= 1'b0;
      end else begin
         if (status_clr) begin
            r_overflow   <= 1'b0;
            r_ackTimeout <= 1'b0;
         end
         if (w_overflowSet) begin
            r_overflow <= 1'b1;
         end
         if (w_ackTimeoutSet) begin
            r_ackTimeout <= 1'b1;
         end
      end
   end

   assign drum_trigger_valid = r_valid;
   assign drum_code          = r_code;
   assign queue_count        = r_count;
   assign overflow           = r_overflow;
   assign ack_timeout        = r_ackTimeout;

endmodule

// File: tb/tb_drum_trigger_queue.sv
// tb_drum_trigger_queue
// Drives drum_trigger_queue with a hand-derived vector table, directed corner
// sequences and random traffic, comparing every cycle against a queue-based
// reference model of the dispatch rules.

module tb_drum_trigger_queue;

   localparam int DEPTH     = 8;
   localparam int NUM_DRUMS = 8;
   localparam int HOLDOFF   = 10;
   localparam int ACK_TO    = 16;
   localparam int CW        = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hitValid = 1'b0;
   logic [3:0]    hitCode = 4'd0;
   logic          commandSent = 1'b0;
   logic          statusClr = 1'b0;
   logic          drumTriggerValid;
   logic [3:0]    drumCode;
   logic [CW-1:0] queueCount;
   logic          overflowFlag;
   logic          ackTimeout;

   int checks = 0;
   int failures = 0;

   // Reference model state: pending codes, outstanding command, per-drum last acceptance time.
   int  modelQ[$];
   bit  modelBusy;
   int  modelIssueEdge;
   int  lastAcc[16];
   bit  modelOvf;
   bit  modelTo;
   bit  modelValid;
   int  modelCode;
   int  edgeCnt = 0;

   typedef struct {
      bit hv;
      int hc;
      bit cs;
      bit sc;
      bit expValid;
      int expCode;
      int expCount;
      bit expOvf;
      bit expTo;
   } vec_t;

   vec_t vecs[$];

   drum_trigger_queue #(
      .DEPTH(DEPTH),
      .NUM_DRUMS(NUM_DRUMS),
      .HOLDOFF_CYCLES(HOLDOFF),
      .ACK_TIMEOUT(ACK_TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .hit_valid(hitValid),
      .hit_code(hitCode),
      .drum_trigger_valid(drumTriggerValid),
      .drum_code(drumCode),
      .command_sent(commandSent),
      .status_clr(statusClr),
      .queue_count(queueCount),
      .overflow(overflowFlag),
      .ack_timeout(ackTimeout)
   );

   // Free-running 10-unit clock.
   initial begin
      forever #5 clk = ~clk;
   end

   function automatic void modelReset();
      modelQ.delete();
      modelBusy  = 1'b0;
      modelOvf   = 1'b0;
      modelTo    = 1'b0;
      modelValid = 1'b0;
      modelCode  = 0;
      for (int i = 0; i < 16; i++) begin
         lastAcc[i] = -1000000;
      end
   endfunction

   // One clock edge of the dispatch rules, expressed in terms of queue contents and elapsed edges.
   function automatic void modelEdge(input bit hv, input int hc, input bit cs, input bit sc);
      bit popNow;
      bit ovfSet;
      bit toSet;
      ovfSet = 1'b0;
      toSet  = 1'b0;
      popNow = !modelBusy && (modelQ.size() > 0);
      if (modelBusy) begin
         if (cs) begin
            modelBusy = 1'b0;
         end else if (edgeCnt - modelIssueEdge == ACK_TO) begin
            toSet     = 1'b1;
            modelBusy = 1'b0;
         end
      end
      modelValid = 1'b0;
      if (popNow) begin
         modelCode      = modelQ.pop_front();
         modelValid     = 1'b1;
         modelBusy      = 1'b1;
         modelIssueEdge = edgeCnt;
      end
      if (hv && (hc < NUM_DRUMS) && (edgeCnt - lastAcc[hc] > HOLDOFF)) begin
         if (modelQ.size() == DEPTH) begin
            ovfSet = 1'b1;
         end else begin
            modelQ.push_back(hc);
            lastAcc[hc] = edgeCnt;
         end
      end
      if (sc) begin
         modelOvf = 1'b0;
         modelTo  = 1'b0;
      end
      if (ovfSet) modelOvf = 1'b1;
      if (toSet)  modelTo  = 1'b1;
      edgeCnt++;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", name, edgeCnt, actual, expected);
      end
   endtask

   task automatic compareModel();
      checkOutput("model_valid", int'(drumTriggerValid), int'(modelValid));
      checkOutput("model_code", int'(drumCode), modelCode);
      checkOutput("model_count", int'(queueCount), modelQ.size());
      checkOutput("model_overflow", int'(overflowFlag), int'(modelOvf));
      checkOutput("model_ack_timeout", int'(ackTimeout), int'(modelTo));
   endtask

   // Present one cycle of inputs, clock it, advance the model and compare just after the edge.
   task automatic applyStimulus(input bit hv, input int hc, input bit cs, input bit sc);
      hitValid    = hv;
      hitCode     = 4'(hc);
      commandSent = cs;
      statusClr   = sc;
      @(posedge clk);
      modelEdge(hv, hc, cs, sc);
      #1;
      compareModel();
      hitValid    = 1'b0;
      hitCode     = 4'd0;
      commandSent = 1'b0;
      statusClr   = 1'b0;
   endtask

   // Asynchronous reset asserted and released mid-cycle, outputs checked while held.
   task automatic doReset();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("reset_count", int'(queueCount), 0);
      checkOutput("reset_valid", int'(drumTriggerValid), 0);
      checkOutput("reset_code", int'(drumCode), 0);
      checkOutput("reset_overflow", int'(overflowFlag), 0);
      checkOutput("reset_ack_timeout", int'(ackTimeout), 0);
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      int issuedFour;

      $display("[TB] start");
      modelReset();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;

      // Reset in the middle of WAIT_ACK with three entries still queued.
      applyStimulus(1, 0, 0, 0);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(1, 2, 0, 0);
      applyStimulus(1, 6, 0, 0);
      checkOutput("pre_reset_count", int'(queueCount), 3);
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0);
         checkOutput("post_reset_no_pulse", int'(drumTriggerValid), 0);
      end

      // Hand-derived vectors: single issue, ordered back-to-back issue, invalid code, holdoff drop.
      doReset();
      vecs.push_back(vec_t'{1, 3, 0, 0, 0, 0, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 0, 0, 1, 3, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 0, 0, 0, 3, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 1, 0, 0, 3, 0, 0, 0});
      vecs.push_back(vec_t'{1, 1, 1, 0, 0, 3, 1, 0, 0});
      vecs.push_back(vec_t'{1, 2, 0, 0, 1, 1, 1, 0, 0});
      vecs.push_back(vec_t'{1, 5, 0, 0, 0, 1, 2, 0, 0});
      vecs.push_back(vec_t'{0, 0, 0, 0, 0, 1, 2, 0, 0});
      vecs.push_back(vec_t'{0, 0, 1, 0, 0, 1, 2, 0, 0});
      vecs.push_back(vec_t'{0, 0, 0, 0, 1, 2, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 1, 0, 0, 2, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 0, 0, 1, 5, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 1, 0, 0, 5, 0, 0, 0});
      vecs.push_back(vec_t'{1, 9, 0, 0, 0, 5, 0, 0, 0});
      vecs.push_back(vec_t'{1, 3, 0, 0, 0, 5, 1, 0, 0});
      vecs.push_back(vec_t'{0, 0, 0, 0, 1, 3, 0, 0, 0});
      vecs.push_back(vec_t'{1, 3, 0, 0, 0, 3, 0, 0, 0});
      vecs.push_back(vec_t'{0, 0, 1, 0, 0, 3, 0, 0, 0});
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].hv, vecs[i].hc, vecs[i].cs, vecs[i].sc);
         checkOutput($sformatf("vec%0d_valid", i), int'(drumTriggerValid), int'(vecs[i].expValid));
         checkOutput($sformatf("vec%0d_code", i), int'(drumCode), vecs[i].expCode);
         checkOutput($sformatf("vec%0d_count", i), int'(queueCount), vecs[i].expCount);
         checkOutput($sformatf("vec%0d_overflow", i), int'(overflowFlag), int'(vecs[i].expOvf));
         checkOutput($sformatf("vec%0d_ack_timeout", i), int'(ackTimeout), int'(vecs[i].expTo));
      end

      // Holdoff window: code 4 at t=0, 5 and 11 with every command acked promptly.
      doReset();
      issuedFour = 0;
      for (int t = 0; t < 20; t++) begin
         applyStimulus((t == 0) || (t == 5) || (t == 11), 4, 1, 0);
         if (drumTriggerValid && (drumCode == 4'd4)) issuedFour++;
      end
      checkOutput("holdoff_issue_count", issuedFour, 2);
      checkOutput("holdoff_overflow", int'(overflowFlag), 0);

      // Stalled fill to overflow, set-vs-clear, timeout, then push and pop together while full.
      doReset();
      for (int c = 0; c < 8; c++) applyStimulus(1, c, 0, 0);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0);
      checkOutput("fill_count", int'(queueCount), 8);
      checkOutput("fill_no_overflow", int'(overflowFlag), 0);
      applyStimulus(1, 1, 0, 1);
      checkOutput("overflow_set_wins", int'(overflowFlag), 1);
      checkOutput("overflow_count", int'(queueCount), 8);
      applyStimulus(0, 0, 0, 1);
      checkOutput("overflow_cleared", int'(overflowFlag), 0);
      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 0);
      checkOutput("timeout_not_yet", int'(ackTimeout), 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("timeout_set", int'(ackTimeout), 1);
      applyStimulus(1, 2, 0, 0);
      checkOutput("full_pushpop_count", int'(queueCount), 8);
      checkOutput("full_pushpop_valid", int'(drumTriggerValid), 1);
      checkOutput("full_pushpop_code", int'(drumCode), 1);
      checkOutput("full_pushpop_no_overflow", int'(overflowFlag), 0);

      // Ack arriving on the very edge the timer expires counts as an ack.
      doReset();
      applyStimulus(1, 7, 0, 0);
      for (int k = 0; k < ACK_TO; k++) applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
      checkOutput("ack_on_expiry_no_flag", int'(ackTimeout), 0);
      applyStimulus(0, 0, 0, 0);
      checkOutput("ack_on_expiry_idle", int'(drumTriggerValid), 0);

      // Random traffic including invalid codes, bounces, stray acks, clears and occasional resets.
      doReset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 599) == 0) begin
            doReset();
         end else begin
            applyStimulus($urandom_range(0, 9) < 4, int'($urandom_range(0, 9)),
                          $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
